// File: rtl/ifq_pkg.sv
// Shared constants and helpers for the instruction-fetch queue.
// Everything derives from the XLEN/DEPTH parameters of the instantiating module.
package ifq_pkg;

  localparam int unsigned MaxXlen = 64;

  // Byte distance between consecutive instruction words.
  function automatic int unsigned pc_step(int unsigned xlen);
    return xlen / 8;
  endfunction

  // Wide enough to hold the value DEPTH itself.
  function automatic int unsigned ctr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Clears the sub-word address bits; callers truncate to their own XLEN.
  function automatic logic [MaxXlen-1:0] align_mask(int unsigned xlen);
    logic [MaxXlen-1:0] step;
    step = MaxXlen'(xlen / 8);
    return ~(step - MaxXlen'(1));
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO holding {pc, word} pairs; flush wins over a same-cycle push.
// Head data is registered storage, so a pushed entry is visible the cycle after the push.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [Width-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [Width-1:0]            head_o,
  output logic [ctr_width(Depth)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = ctr_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !flush_i && (count_q != CntW'(Depth));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited memory requests,
// in-order response capture into a prefetch FIFO, flush-and-redirect and halt.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            halt_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            err_o
);

  localparam int unsigned     CntW      = ctr_width(DEPTH);
  localparam logic [XLEN-1:0] PcStep    = XLEN'(pc_step(XLEN));
  localparam logic [XLEN-1:0] AlignMask = XLEN'(align_mask(XLEN));

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            err_q, err_d;

  logic [CntW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [CntW:0]     occupancy;
  logic [XLEN-1:0]   redirect_pc_aligned;
  logic              req_fire, rsp_ok, rsp_stray, push, pop;

  assign redirect_pc_aligned = redirect_pc_i & AlignMask;
  assign occupancy           = {1'b0, fifo_count} + {1'b0, inflight_q};

  // Gated by reset so no request is presented while the block is held in reset.
  assign imem_req_valid_o = rst_ni && !halt_i && !redirect_valid_i &&
                            (occupancy < (CntW + 1)'(DEPTH));
  assign imem_req_addr_o  = fetch_pc_q;

  assign req_fire  = imem_req_valid_o && imem_req_ready_i;
  assign rsp_ok    = imem_rsp_valid_i && (inflight_q != '0);
  assign rsp_stray = imem_rsp_valid_i && (inflight_q == '0);
  assign push      = rsp_ok && (drop_q == '0);
  assign pop       = inst_valid_o && inst_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    err_d      = err_q | rsp_stray;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(rsp_ok);

    if (req_fire) fetch_pc_d = fetch_pc_q + PcStep;

    if (rsp_ok) begin
      if (drop_q != '0) drop_d = drop_q - CntW'(1);
      else              rsp_pc_d = rsp_pc_q + PcStep;
    end

    // Drop is always a subset of inflight, so this discards every outstanding response.
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      drop_d     = inflight_q - CntW'(rsp_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  ifq_fifo #(
    .Width (2 * XLEN),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .wdata_i ({rsp_pc_q, imem_rsp_data_i}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign inst_valid_o = (fifo_count != '0);
  assign inst_pc_o    = fifo_head[2*XLEN-1:XLEN];
  assign inst_data_o  = fifo_head[XLEN-1:0];
  assign err_o        = err_q;

  a_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occupancy <= (CntW + 1)'(DEPTH));
  a_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) drop_q <= inflight_q);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a randomized run against a queue-based
// model in which each request carries a stale flag set by redirects.
module tb_ifetch_queue;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        halt = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b1;
  logic [31:0] inst_data, inst_pc;
  logic        err;

  logic        w_rst_n = 1'b0;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_inst_valid;
  logic [31:0] w_inst_data, w_inst_pc;
  logic        w_err;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .redirect_valid_i(redirect_valid),
    .redirect_pc_i(redirect_pc), .imem_req_valid_o(imem_req_valid),
    .imem_req_ready_i(imem_req_ready), .imem_req_addr_o(imem_req_addr),
    .imem_rsp_valid_i(imem_rsp_valid), .imem_rsp_data_i(imem_rsp_data),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_data_o(inst_data),
    .inst_pc_o(inst_pc), .err_o(err)
  );

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk_i(clk), .rst_ni(w_rst_n), .halt_i(1'b0), .redirect_valid_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_valid_o(w_req_valid), .imem_req_ready_i(1'b1),
    .imem_req_addr_o(w_req_addr), .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
    .inst_valid_o(w_inst_valid), .inst_ready_i(1'b1), .inst_data_o(w_inst_data),
    .inst_pc_o(w_inst_pc), .err_o(w_err)
  );

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mem_t;
  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mem_t        mem_q[$];
  out_t        out_q[$];
  ent_t        exp_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_err, mem_drove, ready_rand;
  int          mem_lat_min = 1, mem_lat_max = 1, last_due = 0;

  task automatic model_reset();
    mem_q.delete(); out_q.delete(); exp_q.delete();
    m_fetch_pc = RST_PC; m_err = 0; mem_drove = 0; last_due = 0;
    imem_rsp_valid = 0;
  endtask

  function automatic bit m_req_valid();
    return !halt && !redirect_valid && (exp_q.size() + out_q.size() < DEPTH);
  endfunction

  // Called at the negedge: applies the coming clock edge to the model and memory.
  task automatic advance();
    bit   hs_req;
    out_t o;
    ent_t e;
    mem_t m;
    int   due;
    hs_req = imem_req_valid && imem_req_ready;
    if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
    if (imem_rsp_valid) begin
      if (out_q.size() == 0) m_err = 1;
      else begin
        o = out_q.pop_front();
        if (!o.stale) begin
          e.pc = o.addr; e.data = imem_rsp_data; exp_q.push_back(e);
        end
      end
    end
    if (redirect_valid) begin
      exp_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1;
      m_fetch_pc = redirect_pc & ~32'h3;
    end
    if (hs_req) begin
      o.addr = m_fetch_pc; o.stale = 0; out_q.push_back(o);
      m_fetch_pc = m_fetch_pc + 32'd4;
      due = cyc + int'($urandom_range(mem_lat_max, mem_lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = imem_req_addr; m.data = $urandom; m.due = due;
      mem_q.push_back(m);
    end
    if (mem_drove) void'(mem_q.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    mem_drove = 0;
    imem_rsp_valid = 0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1; imem_rsp_data = mem_q[0].data; mem_drove = 1;
    end
    imem_req_ready = ready_rand ? ($urandom_range(99, 0) < 70) : 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    advance();
  endtask

  task automatic apply_reset();
    rst_n = 0; halt = 0; redirect_valid = 0; redirect_pc = '0;
    inst_ready = 1; imem_req_ready = 1; ready_rand = 0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    mem_lat_min = 1; mem_lat_max = 1; inst_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("FAIL first_req: valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL lat_c0: inst_valid %b want 0", inst_valid); end
    advance();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL lat_c1: inst_valid %b want 0", inst_valid); end
    advance();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin errors++; $display("FAIL lat_c2: inst_valid %b pc %h want 1 %h", inst_valid, inst_pc, RST_PC); end
    advance();
  endtask

  task automatic test_sequential();
    logic [31:0] issued[$];
    logic [31:0] popped[$];
    apply_reset();
    mem_lat_min = 1; mem_lat_max = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) issued.push_back(imem_req_addr);
      if (inst_valid && inst_ready) begin
        popped.push_back(inst_pc);
        checks++;
        if (exp_q.size() == 0 || inst_data !== exp_q[0].data) begin errors++; $display("FAIL seq_data: got %h pc %h", inst_data, inst_pc); end
      end
      advance();
    end
    checks++;
    if (issued.size() < 6 || popped.size() < 5) begin
      errors++; $display("FAIL seq_counts: issued %0d popped %0d want >=6 >=5", issued.size(), popped.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (issued[k] !== RST_PC + 32'(4 * k)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", k, issued[k], RST_PC + 32'(4 * k)); end
      end
      for (int k = 0; k < 5; k++) begin
        checks++; if (popped[k] !== RST_PC + 32'(4 * k)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", k, popped[k], RST_PC + 32'(4 * k)); end
      end
    end
  endtask

  task automatic test_credit();
    int nreq = 0;
    apply_reset();
    mem_lat_min = 1; mem_lat_max = 1; inst_ready = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nreq++;
      advance();
    end
    @(negedge clk);
    checks++; if (nreq != DEPTH) begin errors++; $display("FAIL credit_reqs: got %0d want %0d", nreq, DEPTH); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL credit_stall: req_valid %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin errors++; $display("FAIL credit_head: valid %b pc %h want 1 %h", inst_valid, inst_pc, RST_PC); end
    advance();
    inst_ready = 1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL credit_full_pop: req_valid %b want 0", imem_req_valid); end
    advance();
    inst_ready = 0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'h10) begin errors++; $display("FAIL credit_resume: valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC + 32'h10); end
    advance();
  endtask

  task automatic test_redirect_drop();
    logic [31:0] popped[$];
    logic [31:0] first_addr = '0;
    bit          seen = 0;
    apply_reset();
    mem_lat_min = 3; mem_lat_max = 3; inst_ready = 1;
    cycle(); cycle();
    redirect_valid = 1; redirect_pc = 32'h0000_2003;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req: req_valid %b want 0", imem_req_valid); end
    advance();
    redirect_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!seen && imem_req_valid && imem_req_ready) begin seen = 1; first_addr = imem_req_addr; end
      if (inst_valid && inst_ready) begin
        popped.push_back(inst_pc);
        checks++;
        if (exp_q.size() == 0 || inst_data !== exp_q[0].data) begin errors++; $display("FAIL redir_data: got %h pc %h", inst_data, inst_pc); end
      end
      advance();
    end
    checks++; if (first_addr !== 32'h0000_2000) begin errors++; $display("FAIL redir_addr: got %h want 00002000", first_addr); end
    checks++;
    if (popped.size() < 3) begin errors++; $display("FAIL redir_count: got %0d want >=3", popped.size()); end
    else foreach (popped[k]) begin
      checks++; if (popped[k] !== 32'h2000 + 32'(4 * k)) begin errors++; $display("FAIL redir_pc[%0d]: got %h want %h", k, popped[k], 32'h2000 + 32'(4 * k)); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] popped[$];
    int          nreq = 0;
    apply_reset();
    mem_lat_min = 3; mem_lat_max = 3; inst_ready = 1;
    cycle(); cycle();
    halt = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req_valid) nreq++;
      if (inst_valid && inst_ready) popped.push_back(inst_pc);
      advance();
    end
    halt = 0;
    @(negedge clk);
    checks++; if (nreq != 0) begin errors++; $display("FAIL halt_reqs: got %0d want 0", nreq); end
    checks++;
    if (popped.size() != 2) begin errors++; $display("FAIL halt_drain: got %0d words want 2", popped.size()); end
    else begin
      checks++; if (popped[0] !== RST_PC || popped[1] !== RST_PC + 32'h4) begin errors++; $display("FAIL halt_pcs: got %h %h want %h %h", popped[0], popped[1], RST_PC, RST_PC + 32'h4); end
    end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'h8) begin errors++; $display("FAIL halt_resume: valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC + 32'h8); end
    advance();
  endtask

  task automatic test_err();
    logic [31:0] popped[$];
    apply_reset();
    mem_lat_min = 1; mem_lat_max = 1; inst_ready = 0;
    repeat (8) cycle();
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
    advance();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    checks++; if (imem_req_valid !== 1'b0 || inst_pc !== RST_PC) begin errors++; $display("FAIL err_state: req_valid %b pc %h want 0 %h", imem_req_valid, inst_pc, RST_PC); end
    advance();
    halt = 1; inst_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) popped.push_back(inst_pc);
      advance();
    end
    @(negedge clk);
    checks++;
    if (popped.size() != DEPTH) begin errors++; $display("FAIL err_drain: got %0d words want %0d", popped.size(), DEPTH); end
    else foreach (popped[k]) begin
      checks++; if (popped[k] !== RST_PC + 32'(4 * k)) begin errors++; $display("FAIL err_pc[%0d]: got %h want %h", k, popped[k], RST_PC + 32'(4 * k)); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    apply_reset();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic        nv;
    logic [31:0] nd;
    rst_n = 0; imem_rsp_valid = 0;
    @(posedge clk);
    #1;
    w_rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_req_valid) addrs.push_back(w_req_addr);
      if (w_inst_valid) begin
        pcs.push_back(w_inst_pc);
        checks++; if (w_inst_data !== ~w_inst_pc) begin errors++; $display("FAIL wrap_data: got %h want %h", w_inst_data, ~w_inst_pc); end
      end
      nv = w_req_valid; nd = ~w_req_addr;
      @(posedge clk);
      #1;
      w_rsp_valid = nv; w_rsp_data = nd;
    end
    w_rst_n = 0; w_rsp_valid = 0;
    checks++;
    if (addrs.size() < 3 || pcs.size() < 3) begin errors++; $display("FAIL wrap_counts: addrs %0d pcs %0d want >=3", addrs.size(), pcs.size()); end
    else for (int k = 0; k < 3; k++) begin
      checks++; if (addrs[k] !== WRAP_PC + 32'(4 * k)) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, addrs[k], WRAP_PC + 32'(4 * k)); end
      checks++; if (pcs[k] !== WRAP_PC + 32'(4 * k)) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, pcs[k], WRAP_PC + 32'(4 * k)); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    ready_rand = 1; mem_lat_min = 1; mem_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      halt           = ($urandom_range(99, 0) < 10);
      redirect_valid = ($urandom_range(99, 0) < 5);
      redirect_pc    = $urandom;
      inst_ready     = ($urandom_range(99, 0) < 65);
      if (i == 1500) begin
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rnd_midreset: req_valid %b inst_valid %b want 0 0", imem_req_valid, inst_valid); end
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1;
      end
      @(negedge clk);
      checks++; if (imem_req_valid !== m_req_valid()) begin errors++; $display("FAIL rnd_req_valid @%0d: got %b want %b", i, imem_req_valid, m_req_valid()); end
      if (m_req_valid()) begin
        checks++; if (imem_req_addr !== m_fetch_pc) begin errors++; $display("FAIL rnd_req_addr @%0d: got %h want %h", i, imem_req_addr, m_fetch_pc); end
      end
      checks++; if (inst_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_inst_valid @%0d: got %b want %b", i, inst_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (inst_pc !== exp_q[0].pc || inst_data !== exp_q[0].data) begin errors++; $display("FAIL rnd_head @%0d: got %h/%h want %h/%h", i, inst_pc, inst_data, exp_q[0].pc, exp_q[0].data); end
      end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err @%0d: got %b want %b", i, err, m_err); end
      advance();
    end
    ready_rand = 0; halt = 0; redirect_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_credit();
    test_redirect_drop();
    test_halt();
    test_err();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
